run_host: RTL

RUN_HOST -- requirements
Module: run_host

---
 rtl/run_host.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/run_host.sv
// Host-side sequencer: streams operands into data memory, parks/releases the
// processor, watches for completion or timeout, then streams results back out.
module run_host #(
  parameter logic [7:0]  LOAD_BASE = 8'h00,
  parameter int          LOAD_LEN  = 4,
  parameter logic [7:0]  RES_BASE  = 8'h40,
  parameter int          RES_LEN   = 2,
  parameter logic [15:0] TIMEOUT   = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        dm_wr_en,
  output logic [7:0]  dm_addr,
  output logic [7:0]  dm_wr_data,
  input  logic [7:0]  dm_rd_data,
  output logic        cpu_init,
  input  logic        cpu_done,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        run_ok,
  output logic        timeout_err,
  output logic [15:0] cycle_count
);

  typedef enum logic [2:0] {IDLE, LOAD, INIT, RUN, DRAIN, FIN, ERR} state_t;

  localparam logic [7:0]  LOAD_LAST = 8'(LOAD_LEN - 1);
  localparam logic [7:0]  RES_LAST  = 8'(RES_LEN - 1);
  localparam logic [15:0] TO_LAST   = TIMEOUT - 16'd1;

  state_t      state, state_nxt;
  logic [7:0]  idx, idx_nxt;
  logic [15:0] cnt_nxt;
  logic        ok_nxt, to_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 8'd0;
      cycle_count <= 16'd0;
      run_ok      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cycle_count <= cnt_nxt;
      run_ok      <= ok_nxt;
      timeout_err <= to_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cycle_count;
    ok_nxt     = run_ok;
    to_nxt     = timeout_err;
    in_ready   = 1'b0;
    dm_wr_en   = 1'b0;
    dm_addr    = 8'h00;
    dm_wr_data = 8'h00;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    cpu_init   = 1'b1;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (start) begin
        ok_nxt    = 1'b0;
        to_nxt    = 1'b0;
        cnt_nxt   = 16'd0;
        idx_nxt   = 8'd0;
        state_nxt = (LOAD_LEN > 0) ? LOAD : INIT;
      end
      LOAD: begin
        in_ready = 1'b1;
        dm_addr  = LOAD_BASE + idx;
        if (in_valid) begin
          dm_wr_en   = 1'b1;
          dm_wr_data = in_data;
          if (idx == LOAD_LAST) begin
            idx_nxt   = 8'd0;
            state_nxt = INIT;
          end else begin
            idx_nxt = idx + 8'd1;
          end
        end
      end
      // idx doubles as the two-cycle init hold counter
      INIT: begin
        if (idx == 8'd1) begin
          idx_nxt   = 8'd0;
          state_nxt = RUN;
        end else begin
          idx_nxt = idx + 8'd1;
        end
      end
      RUN: begin
        cpu_init = 1'b0;
        if (cycle_count != 16'hFFFF) cnt_nxt = cycle_count + 16'd1;
        if (cpu_done)                    state_nxt = DRAIN;
        else if (cycle_count == TO_LAST) state_nxt = ERR;
      end
      DRAIN: begin
        dm_addr   = RES_BASE + idx;
        out_valid = 1'b1;
        out_data  = dm_rd_data;
        if (out_ready) begin
          if (idx == RES_LAST) begin
            idx_nxt   = 8'd0;
            state_nxt = FIN;
          end else begin
            idx_nxt = idx + 8'd1;
          end
        end
      end
      FIN: begin
        ok_nxt    = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        to_nxt    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // reset kills any write or transfer in the cycle it is asserted
    if (reset) begin
      in_ready   = 1'b0;
      dm_wr_en   = 1'b0;
      dm_addr    = 8'h00;
      dm_wr_data = 8'h00;
      out_valid  = 1'b0;
      out_data   = 8'h00;
      cpu_init   = 1'b1;
      busy       = 1'b0;
    end
  end

endmodule
